subtractor: RTL and testbench
=============================

SUBTRACTOR -- requirements
Module: subtractor

Interface
REQ-001 SHALL have exactly one clock and one reset: clock is clk; reset is rst_n, asynchronous, active-low.
REQ-002 SHALL provide ports:
  clk  input  1  rising-edge clock
  rst_n  input  1  async active-low reset
  in1  input  32  minuend, unsigned/two's-complement
  in2  input  32  subtrahend
  valid_in  input  1  operand pair present, sampled when enable=1
  enable  input  1  pipeline advance; 0 = hold all state
  clear  input  1  synchronous flush, effective only when enable=1
  out  output  32  registered difference in1-in2 mod 2^32
  overflow  output  2  [1] signed overflow, [0] unsigned borrow
  valid_out  output  1  out/overflow correspond to an accepted valid_in
REQ-003 SHALL be parameter-free; widths fixed at 32 (data), 16 (half).

Function
REQ-004 SHALL be a 2-stage pipeline; latency = 2 enabled cycles from sampling in1/in2 to out.
REQ-005 Stage 1 SHALL register: 17-bit low difference {borrow, in1[15:0]-in2[15:0]}, in1[31:16], in2[31:16], valid_in.
REQ-006 Stage 2 SHALL register: low 16 bits of stage-1 difference; upper difference = a_up - b_up - borrow1 (17-bit incl. borrow); sign bits a31, b31; stage-1 valid.
REQ-007 out SHALL equal {upper[15:0], lower[15:0]} from stage-2 registers; no combinational path from inputs to outputs.
REQ-008 overflow[0] SHALL be 1 iff in1 < in2 unsigned (upper 17-bit borrow bit).
REQ-009 overflow[1] SHALL be 1 iff a31 != b31 and out[31] != a31.
REQ-010 Borrow SHALL propagate low to high half exactly one stage later; no borrow lost on stall.
REQ-011 enable=0: all registers SHALL hold, including valid bits; inputs ignored.
REQ-012 enable=1, clear=1: all stage registers SHALL load zero next edge (out=0, overflow=00, valid_out=0); inputs that cycle discarded.
REQ-013 enable=0, clear=1: clear SHALL be ignored.
REQ-014 valid_in=0 with enable=1: data SHALL still advance; valid_out follows valid bit 2 enabled cycles later.
REQ-015 Back-to-back enabled operands SHALL produce one result per cycle, throughput 1.
REQ-016 Wrap-around: results SHALL be modulo 2^32, no saturation.

Reset
REQ-017 rst_n low SHALL asynchronously zero every register: out=0, overflow=00, valid_out=0.
REQ-018 Reset deassertion mid-operation SHALL discard all in-flight data; first valid_out earliest 2 enabled cycles after deassertion.
REQ-019 Reset SHALL dominate enable and clear.

Structure
REQ-020 Shared package/header SHALL hold constants DATA_W=32, HALF_W=16, SUB_LAT=2, overflow bit indices OF_SIGNED=1, OF_UNSIGNED=0.
REQ-021 One combinational sub-module sub16_bw (16-bit subtract with borrow-in, 17-bit result incl. borrow-out) SHALL be instantiated twice (low half borrow-in=0, high half borrow-in=stage-1 borrow).
REQ-022 All sequential logic SHALL reside in subtractor; sub16_bw purely combinational.

Verification
REQ-023 in1=5, in2=3, valid_in=1, enable=1 -> 2 cycles later out=0x00000002, overflow=00, valid_out=1.
REQ-024 in1=0x00010000, in2=0x00000001 -> out=0x0000FFFF, overflow=00 (cross-half borrow).
REQ-025 in1=0x00000000, in2=0x00000001 -> out=0xFFFFFFFF, overflow=01; in1=0x80000000, in2=1 -> out=0x7FFFFFFF, overflow=10.
REQ-026 Stream 3 operands, drop enable for 3 cycles after first -> out/valid_out frozen during stall, remaining results in order after resume, no borrow corruption.
REQ-027 clear=1 with enable=0 -> no change; clear=1 with enable=1 -> next edge out=0, overflow=00, valid_out=0.
REQ-028 Assert rst_n=0 asynchronously between edges with data in flight -> outputs zero immediately; after release, no stale valid_out.

Source files
------------

// File: rtl/subtractor_pkg.sv
// Shared widths, latency and overflow bit positions for the pipelined subtractor,
// plus the packed layouts of its two stage registers.
package subtractor_pkg;

  localparam int DATA_W      = 32;
  localparam int HALF_W      = 16;
  localparam int SUB_LAT     = 2;
  localparam int OF_SIGNED   = 1;
  localparam int OF_UNSIGNED = 0;

  // Stage 1: low-half difference with its borrow in the MSB, raw upper halves.
  typedef struct packed {
    logic [HALF_W:0]   lo_diff;
    logic [HALF_W-1:0] a_up;
    logic [HALF_W-1:0] b_up;
    logic              valid;
  } stage1_t;

  // Stage 2: final halves; up[HALF_W] is the full 32-bit unsigned borrow.
  typedef struct packed {
    logic [HALF_W-1:0] lo;
    logic [HALF_W:0]   up;
    logic              a31;
    logic              b31;
    logic              valid;
  } stage2_t;

endpackage

// File: rtl/subtractor_sub16_bw.sv
// 16-bit subtract with borrow-in; diff[16] is the borrow-out.
module sub16_bw
  import subtractor_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              borrow_in,
  output logic [HALF_W:0]   diff
);

  // Zero-extended subtraction: a negative result wraps and sets the top bit.
  assign diff = {1'b0, a} - {1'b0, b} - {{HALF_W{1'b0}}, borrow_in};

endmodule

// File: rtl/subtractor.sv
// Two-stage 32-bit subtractor: low half in stage 1, high half with the carried
// borrow in stage 2. All state lives here; sub16_bw is purely combinational.
module subtractor
  import subtractor_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic              valid_in,
  input  logic              enable,
  input  logic              clear,
  output logic [DATA_W-1:0] out,
  output logic [1:0]        overflow,
  output logic              valid_out
);

  // Valid semantics: there is no backpressure. valid_in is captured on every
  // enabled edge alongside the data and travels with it; valid_out marks the
  // cycle whose out/overflow belong to an accepted operand pair. enable=0
  // freezes everything, valid bits included.

  stage1_t s1_q, s1_d;
  stage2_t s2_q, s2_d;

  logic [HALF_W:0] lo_res;
  logic [HALF_W:0] up_res;

  sub16_bw u_sub_lo (
    .a         (in1[HALF_W-1:0]),
    .b         (in2[HALF_W-1:0]),
    .borrow_in (1'b0),
    .diff      (lo_res)
  );

  sub16_bw u_sub_hi (
    .a         (s1_q.a_up),
    .b         (s1_q.b_up),
    .borrow_in (s1_q.lo_diff[HALF_W]),
    .diff      (up_res)
  );

  always_comb begin
    s1_d         = '0;
    s1_d.lo_diff = lo_res;
    s1_d.a_up    = in1[DATA_W-1:HALF_W];
    s1_d.b_up    = in2[DATA_W-1:HALF_W];
    s1_d.valid   = valid_in;

    s2_d         = '0;
    s2_d.lo      = s1_q.lo_diff[HALF_W-1:0];
    s2_d.up      = up_res;
    s2_d.a31     = s1_q.a_up[HALF_W-1];
    s2_d.b31     = s1_q.b_up[HALF_W-1];
    s2_d.valid   = s1_q.valid;
  end

  // The stage-1 borrow is held in s1_q.lo_diff, so a stall cannot lose it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (enable) begin
      if (clear) begin
        s1_q <= '0;
        s2_q <= '0;
      end else begin
        s1_q <= s1_d;
        s2_q <= s2_d;
      end
    end
  end

  assign out       = {s2_q.up[HALF_W-1:0], s2_q.lo};
  assign valid_out = s2_q.valid;

  always_comb begin
    overflow              = '0;
    overflow[OF_UNSIGNED] = s2_q.up[HALF_W];
    overflow[OF_SIGNED]   = (s2_q.a31 != s2_q.b31) && (out[DATA_W-1] != s2_q.a31);
  end

endmodule

// File: tb/tb_subtractor.sv
// Bench for subtractor: directed vector table, stall/clear/reset sequences and
// randomized traffic checked against an arithmetic reference pipeline.
module tb_subtractor;

  localparam int W = 35;  // {valid, overflow[1:0], diff[31:0]}

  logic        clk;
  logic        rst_n;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        valid_in;
  logic        enable;
  logic        clear;
  logic [31:0] out;
  logic [1:0]  overflow;
  logic        valid_out;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];

  subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1       (in1),
    .in2       (in2),
    .valid_in  (valid_in),
    .enable    (enable),
    .clear     (clear),
    .out       (out),
    .overflow  (overflow),
    .valid_out (valid_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_entry(input logic [31:0] a, input logic [31:0] b,
                                             input logic v);
    longint    sa;
    logic [1:0] ov;
    logic [31:0] d;
    d  = a - b;
    sa = longint'($signed(a)) - longint'($signed(b));
    ov[1] = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
    ov[0] = (a < b);
    return {v, ov, d};
  endfunction

  task automatic model_flush();
    exp_q = {};
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  // ---------------- checking ----------------
  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got v=%0b ov=%02b out=%08h, want v=%0b ov=%02b out=%08h",
               name, act[34], act[33:32], act[31:0], req[34], req[33:32], req[31:0]);
    end
  endtask

  task automatic check_model(input string name);
    cmp(name, {valid_out, overflow, out}, exp_q[0]);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic v,
                      input logic en, input logic clr, input string name);
    in1 = a; in2 = b; valid_in = v; enable = en; clear = clr;
    @(posedge clk);
    if (rst_n && en) begin
      if (clr) model_flush();
      else begin
        exp_q.delete(0);
        exp_q.push_back(ref_entry(a, b, v));
      end
    end
    #1;
    check_model(name);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic [1:0]  ov;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [W-1:0] held;
    logic [31:0]  ra, rb;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 2'b00};
    vecs[1] = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 2'b00};
    vecs[2] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 2'b01};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 2'b10};
    vecs[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 2'b11};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2'b00};
    vecs[6] = '{32'h1234_5678, 32'h1234_5679, 32'hFFFF_FFFF, 2'b01};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 2'b00};

    rst_n = 1'b0; in1 = '0; in2 = '0; valid_in = 0; enable = 0; clear = 0;
    model_flush();
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_state", {valid_out, overflow, out}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: issue one operand, then one bubble, then compare.
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].a, vecs[i].b, 1'b1, 1'b1, 1'b0, "vec_issue");
      step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "vec_bubble");
      cmp($sformatf("vec%0d", i), {valid_out, overflow, out}, {1'b1, vecs[i].ov, vecs[i].d});
    end
    step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "drain");

    // Back-to-back stream with a three-cycle stall while a borrow sits in stage 1.
    step(32'h0002_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0, "stall_a");
    held = {valid_out, overflow, out};
    for (int i = 0; i < 3; i++) begin
      step($urandom, $urandom, 1'b1, 1'b0, 1'b0, "stall_hold");
      cmp("stall_frozen", {valid_out, overflow, out}, held);
    end
    step(32'h0000_0000, 32'h0000_0002, 1'b1, 1'b1, 1'b0, "stall_b");
    cmp("stall_res_a", {valid_out, overflow, out}, {1'b1, 2'b00, 32'h0001_FFFF});
    step(32'h9000_0000, 32'h1000_0001, 1'b1, 1'b1, 1'b0, "stall_c");
    step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "stall_drain1");
    step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "stall_drain2");

    // Clear is ignored while stalled, flushes when enabled.
    step(32'h0000_0009, 32'h0000_0004, 1'b1, 1'b1, 1'b0, "clr_a");
    step(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1, 1'b0, "clr_b");
    held = {valid_out, overflow, out};
    step(32'h0000_0007, 32'h0000_0001, 1'b1, 1'b0, 1'b1, "clr_ignored");
    cmp("clr_no_effect", {valid_out, overflow, out}, held);
    step(32'h0000_0007, 32'h0000_0001, 1'b1, 1'b1, 1'b1, "clr_flush");
    cmp("clr_zero", {valid_out, overflow, out}, '0);
    step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "clr_after");
    cmp("clr_no_stale", {valid_out, overflow, out}, '0);

    // Asynchronous reset between edges with data in flight.
    step(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 1'b0, "rst_a");
    step(32'h0000_0010, 32'h0000_0001, 1'b1, 1'b1, 1'b0, "rst_b");
    #3 rst_n = 1'b0;
    #1;
    cmp("async_rst_zero", {valid_out, overflow, out}, '0);
    model_flush();
    #2 rst_n = 1'b1;
    step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "post_rst1");
    step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, "post_rst2");

    // Randomized traffic; operands biased toward half-boundary and sign edges.
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra[15:0] = 16'h0000;
        1: rb[15:0] = 16'hFFFF;
        2: begin ra[31] = 1'b1; rb[31] = 1'b0; end
        default: ;
      endcase
      step(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 30) == 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
